sonata_clkgen_seq: RTL and testbench

//  Single-clock clock-enable and reset sequencer for the Sonata FPGA top level.

---
 rtl/sonata_clkgen_seq.sv | 100 ++++++++++
 tb/tb_sonata_clkgen_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sonata_clkgen_seq.sv
// Clock-enable strobes and sequenced domain resets derived from the single board clock.
// Phase accumulators give exact long-run strobe rates; resets release peri -> sys -> usb.
module sonata_clkgen_seq #(
  parameter int unsigned InClkFreq     = 100_000_000,
  parameter int unsigned SysClkFreq    = 50_000_000,
  parameter int unsigned PeriClkFreq   = 25_000_000,
  parameter int unsigned UsbClkFreq    = 48_000_000,
  parameter int unsigned RstHoldCycles = 200
) (
  input  logic IO_CLK,
  input  logic IO_RST,
  output logic IO_CLK_BUF,
  output logic clk_sys_en,
  output logic clk_peri_en,
  output logic clk_usb_en,
  output logic rst_peri_n,
  output logic rst_sys_n,
  output logic rst_usb_n,
  output logic locked
);

  if (SysClkFreq == 0 || SysClkFreq > InClkFreq) begin : gen_sys_freq_err
    $error("SysClkFreq must be in 1..InClkFreq");
  end
  if (PeriClkFreq == 0 || PeriClkFreq > InClkFreq) begin : gen_peri_freq_err
    $error("PeriClkFreq must be in 1..InClkFreq");
  end
  if (UsbClkFreq == 0 || UsbClkFreq > InClkFreq) begin : gen_usb_freq_err
    $error("UsbClkFreq must be in 1..InClkFreq");
  end
  if (RstHoldCycles < 1 || RstHoldCycles > 255) begin : gen_hold_err
    $error("RstHoldCycles must be in 1..255");
  end

  localparam logic [32:0] InFreqW   = 33'(InClkFreq);
  localparam logic [32:0] SysFreqW  = 33'(SysClkFreq);
  localparam logic [32:0] PeriFreqW = 33'(PeriClkFreq);
  localparam logic [32:0] UsbFreqW  = 33'(UsbClkFreq);
  localparam logic [7:0]  HoldW     = 8'(RstHoldCycles);

  logic mainclk_buf;

  // Behavioural pass-through; the FPGA flow maps this net onto a global buffer.
  assign mainclk_buf = IO_CLK;
  assign IO_CLK_BUF  = mainclk_buf;

  logic [31:0] sys_acc_q, peri_acc_q, usb_acc_q;
  logic [32:0] sys_nxt, peri_nxt, usb_nxt;
  logic        sys_wrap, peri_wrap, usb_wrap;
  logic [7:0]  hold_cnt_q;

  // Sums are kept 33 bits wide so acc + F can never wrap before the compare.
  always_comb begin
    sys_nxt   = {1'b0, sys_acc_q} + SysFreqW;
    peri_nxt  = {1'b0, peri_acc_q} + PeriFreqW;
    usb_nxt   = {1'b0, usb_acc_q} + UsbFreqW;
    sys_wrap  = (sys_nxt >= InFreqW);
    peri_wrap = (peri_nxt >= InFreqW);
    usb_wrap  = (usb_nxt >= InFreqW);
  end

  always_ff @(posedge mainclk_buf) begin
    if (IO_RST) begin
      sys_acc_q   <= '0;
      peri_acc_q  <= '0;
      usb_acc_q   <= '0;
      clk_sys_en  <= 1'b0;
      clk_peri_en <= 1'b0;
      clk_usb_en  <= 1'b0;
    end else begin
      sys_acc_q   <= sys_wrap  ? 32'(sys_nxt - InFreqW)  : sys_nxt[31:0];
      peri_acc_q  <= peri_wrap ? 32'(peri_nxt - InFreqW) : peri_nxt[31:0];
      usb_acc_q   <= usb_wrap  ? 32'(usb_nxt - InFreqW)  : usb_nxt[31:0];
      clk_sys_en  <= sys_wrap;
      clk_peri_en <= peri_wrap;
      clk_usb_en  <= usb_wrap;
    end
  end

  // Released resets are sticky until IO_RST; USB waits for a USB strobe so its
  // domain leaves reset aligned to an enabled cycle.
  always_ff @(posedge mainclk_buf) begin
    if (IO_RST) begin
      hold_cnt_q <= '0;
      rst_peri_n <= 1'b0;
      rst_sys_n  <= 1'b0;
      rst_usb_n  <= 1'b0;
      locked     <= 1'b0;
    end else begin
      if (hold_cnt_q != HoldW) begin
        hold_cnt_q <= hold_cnt_q + 8'd1;
      end
      rst_peri_n <= rst_peri_n | (hold_cnt_q == HoldW);
      rst_sys_n  <= rst_sys_n | rst_peri_n;
      rst_usb_n  <= rst_usb_n | (rst_sys_n & clk_usb_en);
      locked     <= rst_peri_n & rst_sys_n & rst_usb_n;
    end
  end

endmodule

// File: tb/tb_sonata_clkgen_seq.sv
// Bench for sonata_clkgen_seq: fixed vector table, hand-written reset sequences, and a
// randomized run against a rate/timing model built from floor(t*F/InClkFreq).
module tb_sonata_clkgen_seq;

  localparam longint InF   = 100_000_000;
  localparam longint SysF  = 50_000_000;
  localparam longint PeriF = 25_000_000;
  localparam longint UsbF  = 48_000_000;
  localparam longint Hold  = 200;
  localparam longint Usb2F = 100_000_000;
  localparam longint Hold2 = 1;

  logic IO_CLK, IO_RST;
  logic clk_buf, sys_en, peri_en, usb_en, rp_n, rs_n, ru_n, lk;
  logic clk_buf2, sys_en2, peri_en2, usb_en2, rp_n2, rs_n2, ru_n2, lk2;

  sonata_clkgen_seq dut (
    .IO_CLK      (IO_CLK),
    .IO_RST      (IO_RST),
    .IO_CLK_BUF  (clk_buf),
    .clk_sys_en  (sys_en),
    .clk_peri_en (peri_en),
    .clk_usb_en  (usb_en),
    .rst_peri_n  (rp_n),
    .rst_sys_n   (rs_n),
    .rst_usb_n   (ru_n),
    .locked      (lk)
  );

  sonata_clkgen_seq #(
    .UsbClkFreq    (100_000_000),
    .RstHoldCycles (1)
  ) dut_corner (
    .IO_CLK      (IO_CLK),
    .IO_RST      (IO_RST),
    .IO_CLK_BUF  (clk_buf2),
    .clk_sys_en  (sys_en2),
    .clk_peri_en (peri_en2),
    .clk_usb_en  (usb_en2),
    .rst_peri_n  (rp_n2),
    .rst_sys_n   (rs_n2),
    .rst_usb_n   (ru_n2),
    .locked      (lk2)
  );

  initial IO_CLK = 1'b0;
  always #5 IO_CLK = ~IO_CLK;

  // Output vector layout: {sys_en, peri_en, usb_en, rst_peri_n, rst_sys_n, rst_usb_n, locked}
  logic [6:0] dut_vec, dut_vec2;
  assign dut_vec  = {sys_en, peri_en, usb_en, rp_n, rs_n, ru_n, lk};
  assign dut_vec2 = {sys_en2, peri_en2, usb_en2, rp_n2, rs_n2, ru_n2, lk2};

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: strobe at release-relative cycle t iff floor(t*F/In) steps up.
  function automatic logic strobe(input longint t, input longint f);
    return ((t * f) / InF) != (((t - 1) * f) / InF);
  endfunction

  function automatic logic [6:0] model_next(input longint t, input longint h, input longint fu,
                                            input logic [6:0] prev);
    logic sy, pe, us, rp, rs, ru, l;
    if (t == 0) return 7'd0;
    sy = strobe(t, SysF);
    pe = strobe(t, PeriF);
    us = strobe(t, fu);
    rp = (t >= h + 1);
    rs = (t >= h + 2);
    ru = prev[1] | (prev[2] & prev[4]);
    l  = prev[3] & prev[2] & prev[1];
    return {sy, pe, us, rp, rs, ru, l};
  endfunction

  longint     m_t = 0;
  logic [6:0] m_vec = '0, m_vec2 = '0;

  task automatic tick(input logic rst);
    IO_RST = rst;
    @(posedge IO_CLK);
    #1;
    if (rst) m_t = 0;
    else m_t++;
    m_vec  = model_next(m_t, Hold, UsbF, m_vec);
    m_vec2 = model_next(m_t, Hold2, Usb2F, m_vec2);
  endtask

  typedef struct {
    longint     t;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[11];

  int cnt_sys, cnt_peri, cnt_usb, cnt_usb2, dbl_ones;
  logic prev_usb;

  initial begin
    tbl[0]  = '{1,   7'b0000000};
    tbl[1]  = '{2,   7'b1000000};
    tbl[2]  = '{3,   7'b0010000};
    tbl[3]  = '{4,   7'b1100000};
    tbl[4]  = '{5,   7'b0010000};
    tbl[5]  = '{200, 7'b1110000};
    tbl[6]  = '{201, 7'b0001000};
    tbl[7]  = '{202, 7'b1001100};
    tbl[8]  = '{203, 7'b0011100};
    tbl[9]  = '{204, 7'b1101110};
    tbl[10] = '{205, 7'b0011111};

    IO_RST = 1'b1;
    tick(1);
    tick(1);
    check("reset_state", 32'(dut_vec), 32'd0);
    check("reset_state_corner", 32'(dut_vec2), 32'd0);
    check("clk_buf_high", 32'(clk_buf), 32'd1);
    #5;
    check("clk_buf_low", 32'(clk_buf), 32'd0);

    // Fixed vectors across startup strobes and the full release sequence.
    for (int i = 0; i < 11; i++) begin
      while (m_t < tbl[i].t) tick(0);
      check($sformatf("table_t%0d", tbl[i].t), 32'(dut_vec), 32'(tbl[i].exp));
    end

    // Corner instance: USB strobe every cycle, one-cycle hold.
    tick(1);
    for (int t = 1; t <= 6; t++) begin
      tick(0);
      check($sformatf("corner_usb_t%0d", t), 32'(usb_en2), 32'd1);
      check($sformatf("corner_rst_t%0d", t), 32'({rp_n2, rs_n2, ru_n2, lk2}),
            32'({t >= 2, t >= 3, t >= 4, t >= 5}));
    end

    // Mid-sequence reset at count 100, then full replay, then reset after lock.
    tick(1);
    while (m_t < 100) tick(0);
    tick(1);
    check("midrst_zero", 32'(dut_vec), 32'd0);
    check("midrst_zero_corner", 32'(dut_vec2), 32'd0);
    while (m_t < 200) tick(0);
    check("replay_peri_low_t200", 32'(rp_n), 32'd0);
    tick(0);
    check("replay_peri_high_t201", 32'(rp_n), 32'd1);
    while (m_t < 204) tick(0);
    check("replay_locked_low_t204", 32'(lk), 32'd0);
    tick(0);
    check("replay_locked_t205", 32'(lk), 32'd1);
    tick(0);
    tick(1);
    check("lockrst_zero", 32'(dut_vec), 32'd0);

    // 1000-cycle USB window: exact count, strobes never back to back at 48%.
    cnt_usb = 0;
    dbl_ones = 0;
    prev_usb = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      tick(0);
      if (usb_en) cnt_usb++;
      if (usb_en && prev_usb) dbl_ones++;
      prev_usb = usb_en;
    end
    check("usb_1000_count", 32'(cnt_usb), 32'd480);
    check("usb_no_double", 32'(dbl_ones), 32'd0);

    // Randomized reset pulses, every cycle compared with the model.
    tick(1);
    for (int c = 0; c < 25000; c++) begin
      tick($urandom_range(0, 1499) == 0);
      check("rand_main", 32'(dut_vec), 32'(m_vec));
      check("rand_corner", 32'(dut_vec2), 32'(m_vec2));
    end

    // Long reset-free run: counts equal floor(N*F/In).
    tick(1);
    cnt_sys = 0; cnt_peri = 0; cnt_usb = 0; cnt_usb2 = 0;
    for (int c = 0; c < 20000; c++) begin
      tick(0);
      cnt_sys  += int'(sys_en);
      cnt_peri += int'(peri_en);
      cnt_usb  += int'(usb_en);
      cnt_usb2 += int'(usb_en2);
    end
    check("long_sys", 32'(cnt_sys), 32'((20000 * SysF) / InF));
    check("long_peri", 32'(cnt_peri), 32'((20000 * PeriF) / InF));
    check("long_usb", 32'(cnt_usb), 32'((20000 * UsbF) / InF));
    check("long_usb_corner", 32'(cnt_usb2), 32'd20000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
